// File: rtl/button_debouncer.sv
// button_debouncer: conditions one raw push-button level into a clean,
// glitch-free level. A change is accepted only after the sampled input has
// disagreed with the current output on DEBOUNCE_CYCLES+1 consecutive edges.
// The accepted level feeds a downstream edge detector. This block does not
// produce a press pulse.
//
// Build option: define BUTTON_DEBOUNCER_SYNC_EN to pass raw_input through a
// two-flop synchronizer first. Real pins need this, and it adds 2 cycles of
// latency. Leave the macro undefined only for sources already in the clk
// domain.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_input,
  output logic debounced_output,
  output logic busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    WAIT_HIGH   = 2'b01,
    STABLE_HIGH = 2'b11,
    WAIT_LOW    = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          busy_q, busy_d;
  logic          s;

`ifdef BUTTON_DEBOUNCER_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // Synchronizer next values: a plain two-stage shift of the pin level.
  always_comb begin
    sync1_d = raw_input;
    sync2_d = sync1_q;
  end

  // Two-flop synchronizer. The FSM only ever sees the second stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign s = sync2_q;
`else
  // The source is already in the clk domain, so the FSM samples it directly.
  assign s = raw_input;
`endif

  // Next state, counter and registered outputs. Any disagreement in WAIT drops
  // back to the stable state with the count cleared, so no credit carries
  // across a bounce.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    busy_d  = 1'b0;
    case (state_q)
      STABLE_LOW: begin
        out_d = 1'b0;
        cnt_d = '0;
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
          busy_d  = 1'b1;
        end
      end
      WAIT_HIGH: begin
        out_d = 1'b0;
        if (!s) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_MAX) begin
          // This edge is the (DEBOUNCE_CYCLES+1)th agreeing sample.
          state_d = STABLE_HIGH;
          out_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
          busy_d = 1'b1;
        end
      end
      STABLE_HIGH: begin
        out_d = 1'b1;
        cnt_d = '0;
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
          busy_d  = 1'b1;
        end
      end
      WAIT_LOW: begin
        out_d = 1'b1;
        if (s) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_MAX) begin
          state_d = STABLE_LOW;
          out_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
          busy_d = 1'b1;
        end
      end
      default: begin
        // Any corrupted encoding recovers to a known-quiet state.
        state_d = STABLE_LOW;
        cnt_d   = '0;
        out_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counter and output registers. Reset clears everything at once, so
  // any pending change is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  end

  // Both outputs come straight from flops, with no combinational path from the pin.
  assign debounced_output = out_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Testbench for button_debouncer with DEBOUNCE_CYCLES=4. The stimulus pushes
// per-edge expectations into a scoreboard queue, and a monitor pops and
// compares them on the falling edge. Hand-computed change positions are also
// checked for each scenario.
module tb_button_debouncer;

  localparam int D = 4;
`ifdef BUTTON_DEBOUNCER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic raw_input;
  logic debounced_output;
  logic busy;

  button_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
    .clk              (clk),
    .rst              (rst),
    .raw_input        (raw_input),
    .debounced_output (debounced_output),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic out;
    logic bsy;
    int   edge_no;
  } exp_t;

  exp_t  sb_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    edge_cnt = 0;
  string scen = "init";

  // Reference: the output flips once the sample has disagreed with it for D+1
  // consecutive edges. busy is high while a run of disagreement is in progress.
  logic m_out = 1'b0;
  int   m_run = 0;
`ifdef BUTTON_DEBOUNCER_SYNC_EN
  logic p1 = 1'b0;
  logic p2 = 1'b0;
`endif

  task automatic check_bit(string name, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 1'b0;
    m_run = 0;
`ifdef BUTTON_DEBOUNCER_SYNC_EN
    p1 = 1'b0;
    p2 = 1'b0;
`endif
  endtask

  // One clock: drive inputs just after the falling edge, then advance the model
  // at the rising edge and queue the expected outputs.
  task automatic step(logic r, logic rs);
    exp_t e;
    logic s;
    @(negedge clk);
    #1;
    raw_input = r;
    rst       = rs;
    @(posedge clk);
    if (rs) begin
      model_reset();
    end else begin
`ifdef BUTTON_DEBOUNCER_SYNC_EN
      s  = p2;
      p2 = p1;
      p1 = r;
`else
      s = r;
`endif
      if (s != m_out) begin
        m_run++;
        if (m_run == D + 1) begin
          m_out = s;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    e.out     = m_out;
    e.bsy     = (m_run != 0);
    e.edge_no = edge_cnt;
    edge_cnt++;
    sb_q.push_back(e);
  endtask

  // Hold a level for n edges. Reports the index of the first edge after which
  // the output changed, or -1 if it never changed.
  task automatic hold(logic r, int n, output int chg);
    logic start_v;
    start_v = debounced_output;
    chg = -1;
    for (int i = 0; i < n; i++) begin
      step(r, 1'b0);
      #1;
      if (chg < 0 && debounced_output !== start_v) chg = i;
    end
  endtask

  // Play bits of pat (bit 0 first) for n edges. Reports the first change index.
  task automatic play(logic [15:0] pat, int n, output int chg);
    logic start_v;
    start_v = debounced_output;
    chg = -1;
    for (int i = 0; i < n; i++) begin
      step(pat[i], 1'b0);
      #1;
      if (chg < 0 && debounced_output !== start_v) chg = i;
    end
  endtask

  // Monitor: on every falling edge, compare the DUT against the oldest
  // expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_bit($sformatf("%s out@edge%0d", scen, e.edge_no), debounced_output, e.out);
        check_bit($sformatf("%s busy@edge%0d", scen, e.edge_no), busy, e.bsy);
      end
    end
  end

  // Watchdog: the stimulus is fixed-length, so this only catches a stalled run.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    logic [15:0] glitch_pat;
    logic [15:0] bounce_pat;
    glitch_pat = 16'h0008;
    bounce_pat = 16'h00E7;
    rst = 1'b1;
    raw_input = 1'b0;

    scen = "reset";
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    scen = "idle";
    hold(1'b0, 4, c);
    check_int("idle no change", c, -1);

    scen = "clean press";
    hold(1'b1, 20, c);
    check_int("press rise edge", c, LAT + D);
    $display("clean press: output rose at edge %0d", c);

    scen = "clean release";
    hold(1'b0, 12, c);
    check_int("release fall edge", c, LAT + D);
    $display("clean release: output fell at edge %0d", c);

    scen = "glitch release";
    hold(1'b1, 12, c);
    check_int("glitch setup rise edge", c, LAT + D);
    play(glitch_pat, 16, c);
    check_int("glitch release fall edge", c, LAT + 8);
    $display("glitch release: output fell at edge %0d", c);

    scen = "bounce";
    play(bounce_pat, 16, c);
    check_int("bounce never rises", c, -1);
    $display("bounce: first change index %0d", c);

    scen = "back-to-back";
    hold(1'b1, LAT + 5, c);
    check_int("b2b press edge", c, LAT + 4);
    hold(1'b0, LAT + 5, c);
    check_int("b2b release edge", c, LAT + 4);
    hold(1'b1, LAT + 5, c);
    check_int("b2b press2 edge", c, LAT + 4);
    hold(1'b0, LAT + 5, c);
    check_int("b2b release2 edge", c, LAT + 4);
    $display("back-to-back: press/release pairs done");

    scen = "mid-wait reset";
    hold(1'b1, LAT + 2, c);
    @(negedge clk);
    #2;
    check_bit("busy before mid-wait reset", busy, 1'b1);
    rst = 1'b1;
    #1;
    check_bit("async reset out", debounced_output, 1'b0);
    check_bit("async reset busy", busy, 1'b0);
    model_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    hold(1'b1, 12, c);
    check_int("requalify rise after reset", c, LAT + D);
    $display("mid-wait reset: output rose at edge %0d after release", c);

    scen = "final release";
    hold(1'b0, 12, c);
    check_int("final fall edge", c, LAT + D);

    @(negedge clk);
    @(negedge clk);
    check_int("scoreboard drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions one raw mechanical push-button for the input stage. Optionally synchronizes the asynchronous button level into `clk`, then suppresses contact bounce with a counter-qualified state machine. Emits a clean, glitch-free level that feeds `generic_input` directly on its `named_input`; the one-cycle press pulse is produced there, not here.

## Interface
- `DEBOUNCE_CYCLES`, default 1000: number of additional consecutive agreeing samples required before the output changes. Legal range ≥ 1. Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- `clk` input 1: system clock; all state changes on posedge.
- `rst` input 1: reset, asynchronous, active-high.
- `raw_input` input 1: button level straight from the pin; asynchronous, may bounce.
- `debounced_output` input→output 1: qualified button level; drives `generic_input.named_input`.
- `busy` output 1: high while a level change is being qualified (WAIT states).

## Operation
- Sample `s`: the synchronized `raw_input` (see Configuration). The FSM compares `s` against `debounced_output` on every edge.
- States:
  - STABLE_LOW: output 0, counter 0.
    - If `s`=1, go to WAIT_HIGH with counter 1.
  - WAIT_HIGH: output 0, busy 1.
    - If `s`=0, return to STABLE_LOW and clear the counter. This is a bounce, and nothing is emitted.
    - If `s`=1 and counter = `DEBOUNCE_CYCLES`, go to STABLE_HIGH, set output 1, clear the counter.
    - Otherwise increment the counter.
  - STABLE_HIGH and WAIT_LOW: exact mirror of the two states above.
- Net rule: the output changes on the edge at which `s` has been sampled different from the output on `DEBOUNCE_CYCLES+1` consecutive edges.
- The counter never exceeds `DEBOUNCE_CYCLES` and never wraps. It is cleared on every return to a STABLE state.
- Any disagreement during WAIT restarts qualification from zero. There is no partial credit across bounces.
- Reset values, applied immediately on `rst` high: state STABLE_LOW, `debounced_output`=0, `busy`=0, counter 0, synchronizer flops 0.
- Reset mid-WAIT: the pending change is discarded. A button still held after reset release must requalify fully from STABLE_LOW.
- Deassertion of `rst` takes effect at the first posedge after release.
- Illegal or unused state encodings recover to STABLE_LOW on the next edge.

## Timing
- With synchronizer:
  - `raw_input` change set up before edge 0 → `s` valid for FSM sampling at edge 2.
  - Output changes at edge 2+`DEBOUNCE_CYCLES`.
- Without synchronizer:
  - First FSM sample is at edge 0.
  - Output changes at edge `DEBOUNCE_CYCLES`.
- `busy`:
  - Registered.
  - High from the edge entering WAIT through the edge before the output changes.
  - Falls on the same edge the output changes, or on the edge that detects a bounce.
- Output and `busy` are purely registered, with no combinational path from `raw_input`. This keeps the edge detector downstream glitch-free.
- Minimum pulse width passed: `DEBOUNCE_CYCLES+1` cycles. Anything shorter is absorbed.

## Configuration
- `BUTTON_DEBOUNCER_SYNC_EN` defined:
  - `raw_input` passes through a two-flop synchronizer; `s` is the second flop.
  - Adds 2 cycles of latency.
  - Required for real pins.
- Not defined:
  - `s` = `raw_input` sampled directly by the FSM.
  - Intended only for sources already in the `clk` domain, or for fast simulation.
  - All other behaviour is identical.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Reset: assert `rst` asynchronously between edges while in WAIT_HIGH → `debounced_output`=0 and `busy`=0 before the next edge. After release with `raw_input` held 1, output rises at edge 6 counted from the first edge after release (SYNC_EN defined).
- Clean press, SYNC_EN defined: `raw_input` 0→1 before edge 0, held 20 cycles → output 0 through edge 5, 1 from edge 6. `busy`=1 after edges 2–5 and 0 after edge 6.
- Bounce rejection: `raw_input` high for 3 cycles, low for 2, high for 3, then low → `debounced_output` never rises. `busy` pulses and returns to 0.
- Release: from STABLE_HIGH, `raw_input` 1→0 before edge 0 and held → output falls at edge 6. A 1-cycle high glitch at edge 3 restarts qualification, and the fall moves to edge 2 after the glitch's end + 4.
- SYNC_EN not defined: `raw_input` 0→1 before edge 0 → output rises at edge 4. Back-to-back press/release each take 5 consecutive samples.
- Integration with `generic_input`: one 40-cycle bouncy press → exactly one `named_output` high period downstream.
